// File: rtl/arbitern_wrr_pkt.sv
// arbitern_wrr_pkt
// Weighted round-robin packet arbiter. N requesters compete for one shared
// DW-bit stream port. A packet is never interleaved with another. A granted
// requester may send up to i_weight[k] packets back to back. After that, or
// when it runs out of packets, the grant moves on in round-robin order.
//
// Ports
//   i_clk       clock; all logic on the rising edge
//   i_reset     synchronous, active-high reset
//   i_valid[k]  requester k presents a beat
//   o_ready[k]  requester k's beat is taken this cycle (one-hot or zero)
//   i_data[k]   requester k beat data
//   i_last[k]   requester k end-of-packet flag
//   i_weight[k] packets per turn for requester k; sampled at turn start, 0 acts as 1
//   o_valid     registered output beat valid
//   i_ready     downstream accepts the output beat
//   o_data      registered output beat data
//   o_last      registered output end-of-packet
//   o_grant_id  index of the requester that sourced the output beat
module arbitern_wrr_pkt #(
   parameter int N  = 4,
   parameter int DW = 16,
   parameter int WW = 4
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [N-1:0]         i_valid,
   output logic [N-1:0]         o_ready,
   input  logic [DW-1:0]        i_data [N],
   input  logic [N-1:0]         i_last,
   input  logic [WW-1:0]        i_weight [N],
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [DW-1:0]        o_data,
   output logic                 o_last,
   output logic [$clog2(N)-1:0] o_grant_id
);

   localparam int IW = $clog2(N);
   localparam logic [WW-1:0] CRED_ONE = {{(WW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_ARB  = 2'd0,   // no owner, free arbitration
      ST_LOCK = 2'd1,   // mid-packet, owner only
      ST_HOLD = 2'd2    // between packets, owner still has credit
   } state_t;

   state_t          state_r, state_nxt_s;
   logic [IW-1:0]   ptr_r, ptr_nxt_s;
   logic [IW-1:0]   owner_r, owner_nxt_s;
   logic [WW-1:0]   credit_r, credit_nxt_s;

   logic            load_s;
   logic            any_s;
   logic [IW-1:0]   base_s;
   logic [IW-1:0]   win_s;
   int              idx_s;
   logic [IW-1:0]   sel_s;
   logic            sel_valid_s;
   logic            sel_last_s;
   logic            new_turn_s;
   logic            forfeit_s;
   logic [WW-1:0]   cred_cur_s;
   logic            xfer_s;

   // Round-robin search: first valid requester after base, wrapping modulo N.
   // A forfeit in HOLD searches from the owner, as if ptr already held it.
   always_comb begin
      base_s = (state_r == ST_HOLD) ? owner_r : ptr_r;
      win_s  = {IW{1'b0}};
      idx_s  = 0;
      // Walk from lowest to highest priority so the highest-priority hit wins.
      for (int i = N; i >= 1; i--) begin
         idx_s = int'(base_s) + i;
         idx_s = (idx_s >= N) ? (idx_s - N) : idx_s;
         win_s = i_valid[IW'(idx_s)] ? IW'(idx_s) : win_s;
      end
   end

   // Source selection, credit for this beat, transfer strobe and o_ready.
   always_comb begin
      any_s     = |i_valid;
      load_s    = !o_valid || i_ready;
      forfeit_s = (state_r == ST_HOLD) && load_s && !i_valid[owner_r];
      case (state_r)
         ST_ARB: begin
            sel_s       = win_s;
            sel_valid_s = any_s;
            new_turn_s  = 1'b1;
         end
         ST_LOCK: begin
            // Never switch mid-packet; a missing owner beat is a bubble.
            sel_s       = owner_r;
            sel_valid_s = i_valid[owner_r];
            new_turn_s  = 1'b0;
         end
         ST_HOLD: begin
            if (i_valid[owner_r]) begin
               sel_s       = owner_r;
               sel_valid_s = 1'b1;
               new_turn_s  = 1'b0;
            end else begin
               sel_s       = win_s;
               sel_valid_s = any_s;
               new_turn_s  = 1'b1;
            end
         end
         default: begin
            sel_s       = owner_r;
            sel_valid_s = 1'b0;
            new_turn_s  = 1'b0;
         end
      endcase
      if (new_turn_s) begin
         cred_cur_s = (i_weight[sel_s] == {WW{1'b0}}) ? CRED_ONE : i_weight[sel_s];
      end else begin
         cred_cur_s = credit_r;
      end
      xfer_s     = load_s && sel_valid_s;
      sel_last_s = i_last[sel_s];
      o_ready    = {N{1'b0}};
      if (xfer_s) begin
         o_ready[sel_s] = 1'b1;
      end else begin
         o_ready = {N{1'b0}};
      end
   end

   // Next-state logic for the grant FSM, pointer, owner and credit.
   always_comb begin
      state_nxt_s  = state_r;
      ptr_nxt_s    = forfeit_s ? owner_r : ptr_r;
      owner_nxt_s  = owner_r;
      credit_nxt_s = credit_r;
      if (xfer_s) begin
         owner_nxt_s = sel_s;
         if (!sel_last_s) begin
            credit_nxt_s = cred_cur_s;
            state_nxt_s  = ST_LOCK;
         end else if (cred_cur_s == CRED_ONE) begin
            // Turn over: this requester drops to lowest priority.
            credit_nxt_s = {WW{1'b0}};
            ptr_nxt_s    = sel_s;
            state_nxt_s  = ST_ARB;
         end else begin
            credit_nxt_s = cred_cur_s - CRED_ONE;
            state_nxt_s  = ST_HOLD;
         end
      end else if (forfeit_s) begin
         // Owner left with credit and nobody else wants the port.
         state_nxt_s = ST_ARB;
      end else begin
         state_nxt_s = state_r;
      end
   end

   // State registers and the fully registered output stage.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_r    <= ST_ARB;
         ptr_r      <= IW'(N - 1);
         owner_r    <= {IW{1'b0}};
         credit_r   <= {WW{1'b0}};
         o_valid    <= 1'b0;
         o_data     <= {DW{1'b0}};
         o_last     <= 1'b0;
         o_grant_id <= {IW{1'b0}};
      end else begin
         state_r  <= state_nxt_s;
         ptr_r    <= ptr_nxt_s;
         owner_r  <= owner_nxt_s;
         credit_r <= credit_nxt_s;
         if (xfer_s) begin
            o_valid    <= 1'b1;
            o_data     <= i_data[sel_s];
            o_last     <= sel_last_s;
            o_grant_id <= sel_s;
         end else if (i_ready) begin
            o_valid <= 1'b0;
         end else begin
            o_valid <= o_valid;
         end
      end
   end

endmodule

// File: doc/arbitern_wrr_pkt.md
Name: arbiterN_wrr_pkt

Overview:
- N-input weighted round-robin packet arbiter with valid/ready handshakes on every requester and on the single output.
- Shares one 16-bit downstream stream port between N packet sources.
- A packet never interleaves. A granted source may send up to weight consecutive packets before the grant rotates.
- Output is fully registered. Sits in front of the shared sink that the N sources compete for.

Parameters:
N, 4, number of requesters (2..16).
DW, 16, data width per beat.
WW, 4, width of per-requester weight field.

Ports:
i_clk  input  1  clock; all logic on posedge.
i_reset  input  1  synchronous, active-high reset.
i_valid  input  N  per-requester beat valid.
o_ready  output  N  per-requester beat accepted this cycle.
i_data  input  DW x N (unpacked array [N])  per-requester beat data.
i_last  input  N  per-requester end-of-packet flag for the current beat.
i_weight  input  WW x N (unpacked array [N])  packets per turn. Sampled at turn start. 0 treated as 1.
o_valid  output  1  output beat valid.
i_ready  input  1  downstream accepts output beat.
o_data  output  DW  output beat data.
o_last  output  1  output end-of-packet.
o_grant_id  output  $clog2(N)  index of the requester that sourced the output beat.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is i_reset, synchronous, active-high.
- Reset values:
  - o_valid=0, o_data=0, o_last=0, o_grant_id=0.
  - ptr=N-1, so requester 0 has first priority.
  - state=ARB, owner=0, credit=0.
- Load condition: load = !o_valid || i_ready. A beat is transferred from source k when load && sel_valid && sel==k.
  - o_ready[k] is combinational, exactly one-hot or zero, and never asserted when load=0.
- Latency: a beat accepted in cycle t appears on o_* in cycle t+1.
  - With i_ready held high, throughput is 1 beat/cycle with no bubbles, including across packet boundaries and grant switches.
- Output register:
  - On a transfer, o_valid<=1 and o_data/o_last/o_grant_id<=source beat.
  - Else if i_ready, o_valid<=0. o_data/o_last/o_grant_id keep their last values.
  - While o_valid && !i_ready, all o_* are held stable.
- Search order: ptr+1, ptr+2, ..., ptr, modulo N. The first valid requester wins, so the previous holder has lowest priority.
- State ARB:
  - If load and any i_valid: sel=search winner w, owner<=w, credit<=max(i_weight[w],1).
  - If that beat has last=0: state<=LOCK.
  - If last=1 and credit==1: ptr<=w, stay ARB.
  - Otherwise: credit<=credit-1, state<=HOLD.
- State LOCK (mid-packet):
  - Only owner is eligible; other o_ready are 0.
  - If owner is not valid, insert a bubble; never switch.
  - On owner beat with last=1:
    - credit==1: ptr<=owner, state<=ARB.
    - else: credit<=credit-1, state<=HOLD.
- State HOLD (between packets, credit>0):
  - If i_valid[owner]: serve owner. The same transitions as LOCK apply for the first beat; last=0 goes to LOCK.
  - If !i_valid[owner] while load=1: forfeit. ptr<=owner, and arbitrate in the same cycle exactly as in ARB. The search starting at owner+1 cannot pick owner because it is not valid.
  - If load=0: hold state.
- Weight:
  - Weight is sampled only at turn start. Changes mid-turn have no effect until the next turn.
  - credit width is WW. Weight 15 is the maximum.
- Single-beat packets (valid and last in the same cycle) are legal in every state.
- Reset mid-packet discards the lock. The next packet begins arbitration from requester 0.
- Sources must hold valid/data/last stable until o_ready. Violations are undefined.

Test Plan:
- Reset, then all i_valid=4'b1111, all weight=1, every beat last=1, i_ready=1 -> o_grant_id sequence 0,1,2,3,0,... one per cycle. First o_valid is 1 cycle after first o_ready[0].
- Req0 sends 3-beat packet (A0,A1,A2) while req1 is valid throughout, weight=1 -> o_data A0,A1,A2 contiguous with grant_id=0, then req1. o_ready[1]=0 during the lock.
- weight[2]=3, req2 and req3 continuously valid with 1-beat packets -> grant_id 2,2,2,3,2,2,2,3.
- weight[1]=2; req1 sends one packet then drops valid while req2 is valid -> forfeit in the same cycle. Next grant_id=2 with no bubble; ptr=1 afterwards.
- i_ready low for 5 cycles mid-packet -> o_valid/o_data/o_last held, all o_ready=0. Resume with no loss or duplication of beats.
- Assert i_reset in the second beat of a 4-beat packet from req3 -> next cycle o_valid=0. Afterwards req0 wins even though req3 remains valid.
